// File: rtl/back_iconch_controller.sv
// -----------------------------------------------------------------------------
// back_iconch_controller
//
// Channel-side initiator for a single interconnect channel. Up to N_REQ
// consumers raise operand-fetch requests; a round-robin arbiter picks one,
// the controller holds a channel request (producer address + destination
// address) until the producer EU reports success or a timeout expires, and
// the result (data or timeout status) is returned to the winning requester.
//
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   req_valid_i               per-consumer request, held until its response
//   req_src_addr_i            packed producer addresses, slice i = requester i
//   req_dst_addr_i            packed destination addresses, slice i
//   resp_valid_o              one-cycle response pulse
//   resp_idx_o                index of the requester being answered
//   resp_data_o               data captured from the channel (0 on timeout)
//   resp_timeout_o            response is a timeout abort
//   icon_req_valid_o          channel req_valid
//   icon_src_addr_o           channel src_addr
//   icon_data_tx_o            channel data_tx (destination address)
//   icon_data_rx_i            channel data_rx
//   icon_data_valid_rx_i      channel data_valid_rx (not needed: success alone
//                             qualifies the captured word)
//   icon_success_i            channel success
//   flush_i                   synchronous abort of the in-flight transfer
//   busy_o                    controller is not idle
//
// All outputs are decoded from registered state only, so there is no
// combinational path from any icon_* input to an output.
// -----------------------------------------------------------------------------
module back_iconch_controller #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_src_addr_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_dst_addr_i,
    output logic                      resp_valid_o,
    output logic [IDX_W-1:0]          resp_idx_o,
    output logic [DATA_W-1:0]         resp_data_o,
    output logic                      resp_timeout_o,
    output logic                      icon_req_valid_o,
    output logic [ADDR_W-1:0]         icon_src_addr_o,
    output logic [ADDR_W-1:0]         icon_data_tx_o,
    input  logic [DATA_W-1:0]         icon_data_rx_i,
    input  logic                      icon_data_valid_rx_i,
    input  logic                      icon_success_i,
    input  logic                      flush_i,
    output logic                      busy_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Registered state
    state_t              state_r;
    logic [IDX_W-1:0]    rr_ptr_r;
    logic [IDX_W-1:0]    win_r;
    logic [ADDR_W-1:0]   src_r;
    logic [ADDR_W-1:0]   dst_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   data_r;
    logic                tmo_r;

    // Next-state values
    state_t              state_next_s;
    logic [IDX_W-1:0]    rr_next_s;
    logic [IDX_W-1:0]    win_next_s;
    logic [ADDR_W-1:0]   src_next_s;
    logic [ADDR_W-1:0]   dst_next_s;
    logic [CNT_W-1:0]    cnt_next_s;
    logic [DATA_W-1:0]   data_next_s;
    logic                tmo_next_s;

    // Arbitration
    logic [2*N_REQ-1:0]  req2_s;
    logic [N_REQ-1:0]    rot_s;
    logic [IDX_W-1:0]    first_s;
    logic [IDX_W:0]      sum_s;
    logic [IDX_W-1:0]    grant_idx_s;
    logic                grant_found_s;
    logic [ADDR_W-1:0]   sel_src_s;
    logic [ADDR_W-1:0]   sel_dst_s;

    // Success alone qualifies the data word; data_valid_rx is kept only for
    // port completeness.
    logic                unused_ok_s;
    assign unused_ok_s = icon_data_valid_rx_i;

    // Round-robin successor with wrap at N_REQ-1.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        if (idx == IDX_W'(N_REQ - 1)) begin
            res = {IDX_W{1'b0}};
        end else begin
            res = idx + IDX_W'(1);
        end
        return res;
    endfunction

    // Rotate the request vector so bit 0 is the requester at rr_ptr, then
    // find the lowest set bit and map it back to an absolute index.
    always_comb begin
        req2_s        = {req_valid_i, req_valid_i};
        rot_s         = N_REQ'(req2_s >> rr_ptr_r);
        grant_found_s = |req_valid_i;
        first_s       = {IDX_W{1'b0}};
        for (int j = N_REQ - 1; j >= 0; j--) begin
            first_s = rot_s[j] ? IDX_W'(j) : first_s;
        end
        sum_s = {1'b0, rr_ptr_r} + {1'b0, first_s};
        if (sum_s >= (IDX_W + 1)'(N_REQ)) begin
            grant_idx_s = IDX_W'(sum_s - (IDX_W + 1)'(N_REQ));
        end else begin
            grant_idx_s = sum_s[IDX_W-1:0];
        end
    end

    // Select the winner's address slices (one-hot AND-OR mux).
    always_comb begin
        sel_src_s = {ADDR_W{1'b0}};
        sel_dst_s = {ADDR_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_src_s = sel_src_s | (req_src_addr_i[i*ADDR_W +: ADDR_W] &
                                     {ADDR_W{grant_idx_s == IDX_W'(i)}});
            sel_dst_s = sel_dst_s | (req_dst_addr_i[i*ADDR_W +: ADDR_W] &
                                     {ADDR_W{grant_idx_s == IDX_W'(i)}});
        end
    end

    // FSM next-state and datapath update logic.
    always_comb begin
        state_next_s = state_r;
        rr_next_s    = rr_ptr_r;
        win_next_s   = win_r;
        src_next_s   = src_r;
        dst_next_s   = dst_r;
        cnt_next_s   = cnt_r;
        data_next_s  = data_r;
        tmo_next_s   = tmo_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_i) begin
                    state_next_s = ST_IDLE;
                end else if (grant_found_s) begin
                    win_next_s   = grant_idx_s;
                    src_next_s   = sel_src_s;
                    dst_next_s   = sel_dst_s;
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Flush takes priority over a coincident success.
                if (flush_i) begin
                    state_next_s = ST_IDLE;
                    rr_next_s    = next_idx(win_r);
                end else if (icon_success_i) begin
                    data_next_s  = icon_data_rx_i;
                    tmo_next_s   = 1'b0;
                    state_next_s = ST_RESP;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    data_next_s  = {DATA_W{1'b0}};
                    tmo_next_s   = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // The response pulse is already visible this cycle; flush
                // has nothing further to cancel.
                state_next_s = ST_IDLE;
                rr_next_s    = next_idx(win_r);
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= {IDX_W{1'b0}};
            win_r    <= {IDX_W{1'b0}};
            src_r    <= {ADDR_W{1'b0}};
            dst_r    <= {ADDR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            data_r   <= {DATA_W{1'b0}};
            tmo_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            rr_ptr_r <= rr_next_s;
            win_r    <= win_next_s;
            src_r    <= src_next_s;
            dst_r    <= dst_next_s;
            cnt_r    <= cnt_next_s;
            data_r   <= data_next_s;
            tmo_r    <= tmo_next_s;
        end
    end

    // Outputs decoded from registered state; zero outside their state.
    assign busy_o           = (state_r != ST_IDLE);
    assign icon_req_valid_o = (state_r == ST_BUSY);
    assign icon_src_addr_o  = (state_r == ST_BUSY) ? src_r : {ADDR_W{1'b0}};
    assign icon_data_tx_o   = (state_r == ST_BUSY) ? dst_r : {ADDR_W{1'b0}};
    assign resp_valid_o     = (state_r == ST_RESP);
    assign resp_idx_o       = (state_r == ST_RESP) ? win_r : {IDX_W{1'b0}};
    assign resp_data_o      = (state_r == ST_RESP) ? data_r : {DATA_W{1'b0}};
    assign resp_timeout_o   = (state_r == ST_RESP) & tmo_r;

endmodule

// File: tb/tb_back_iconch_controller.sv
// -----------------------------------------------------------------------------
// tb_back_iconch_controller
//
// Directed scenarios followed by randomized transfers. A transaction-level
// reference model (round-robin pointer + pending-request vector) predicts the
// winner of every arbitration and the channel/response values cycle by cycle.
// -----------------------------------------------------------------------------
module tb_back_iconch_controller;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_src;
    logic [N*AW-1:0]   req_dst;
    logic              resp_valid;
    logic [IW-1:0]     resp_idx;
    logic [DW-1:0]     resp_data;
    logic              resp_timeout;
    logic              icon_req_valid;
    logic [AW-1:0]     icon_src_addr;
    logic [AW-1:0]     icon_data_tx;
    logic [DW-1:0]     icon_data_rx;
    logic              icon_data_valid_rx;
    logic              icon_success;
    logic              flush;
    logic              busy;

    int                checks = 0;
    int                errors = 0;

    // Reference model state
    int                rr_m;
    logic [N-1:0]      req_m;
    logic [AW-1:0]     src_tab [N];
    logic [AW-1:0]     dst_tab [N];

    back_iconch_controller #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req_valid_i          (req_valid),
        .req_src_addr_i       (req_src),
        .req_dst_addr_i       (req_dst),
        .resp_valid_o         (resp_valid),
        .resp_idx_o           (resp_idx),
        .resp_data_o          (resp_data),
        .resp_timeout_o       (resp_timeout),
        .icon_req_valid_o     (icon_req_valid),
        .icon_src_addr_o      (icon_src_addr),
        .icon_data_tx_o       (icon_data_tx),
        .icon_data_rx_i       (icon_data_rx),
        .icon_data_valid_rx_i (icon_data_valid_rx),
        .icon_success_i       (icon_success),
        .flush_i              (flush),
        .busy_o               (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp_valid"},  64'(resp_valid),     64'd0);
        check({tag, "_resp_idx"},    64'(resp_idx),       64'd0);
        check({tag, "_resp_data"},   64'(resp_data),      64'd0);
        check({tag, "_resp_tmo"},    64'(resp_timeout),   64'd0);
        check({tag, "_chan_valid"},  64'(icon_req_valid), 64'd0);
        check({tag, "_chan_src"},    64'(icon_src_addr),  64'd0);
        check({tag, "_chan_dst"},    64'(icon_data_tx),   64'd0);
        check({tag, "_busy"},        64'(busy),           64'd0);
    endtask

    task automatic apply_req();
        req_valid = req_m;
        for (int i = 0; i < N; i++) begin
            req_src[i*AW +: AW] = src_tab[i];
            req_dst[i*AW +: AW] = dst_tab[i];
        end
    endtask

    // Give fresh payloads to requesters that were idle and now request.
    task automatic add_requests(input logic [N-1:0] newbits);
        for (int i = 0; i < N; i++) begin
            if (newbits[i] && !req_m[i]) begin
                src_tab[i] = AW'($urandom);
                dst_tab[i] = AW'($urandom);
            end
        end
        req_m = req_m | newbits;
        apply_req();
    endtask

    // First pending requester scanning upward from the round-robin pointer.
    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (req_m[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    // One transfer from IDLE. Called #1 after a rising edge with requests
    // already applied. succ_at/flush_at are 1-based BUSY cycles (0 = never).
    task automatic do_transfer(input int succ_at, input int flush_at, input bit drop,
                               input bit use_fixed, input logic [DW-1:0] fixed,
                               output int w, output bit flushed);
        logic [DW-1:0] d;
        logic [DW-1:0] exp_d;
        bit            exp_t;
        bit            done;
        int            c;
        w = model_winner();
        flushed = 1'b0;
        done = 1'b0;
        c = 0;
        exp_d = '0;
        exp_t = 1'b0;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_chan_valid", 64'(icon_req_valid), 64'd0);
        while (!done) begin
            @(posedge clk); #1;
            c++;
            check("busy", 64'(busy), 64'd1);
            check("chan_valid", 64'(icon_req_valid), 64'd1);
            check("chan_src", 64'(icon_src_addr), 64'(src_tab[w]));
            check("chan_dst", 64'(icon_data_tx), 64'(dst_tab[w]));
            check("no_resp_in_busy", 64'(resp_valid), 64'd0);
            if (drop && c == 1) req_valid[w] = 1'b0;
            d = use_fixed ? fixed : DW'($urandom);
            icon_data_rx       = d;
            icon_data_valid_rx = 1'($urandom_range(0, 1));
            icon_success       = (c == succ_at);
            flush              = (c == flush_at);
            if (c == flush_at) begin
                done = 1'b1;
                flushed = 1'b1;
            end else if (c == succ_at) begin
                done = 1'b1;
                exp_d = d;
                exp_t = 1'b0;
            end else if (c == TO) begin
                done = 1'b1;
                exp_d = '0;
                exp_t = 1'b1;
            end
        end
        @(posedge clk); #1;
        icon_success       = 1'b0;
        flush              = 1'b0;
        icon_data_rx       = DW'($urandom);
        icon_data_valid_rx = 1'b0;
        check("chan_released", 64'(icon_req_valid), 64'd0);
        check("chan_src_zero", 64'(icon_src_addr), 64'd0);
        if (flushed) begin
            check("flush_busy", 64'(busy), 64'd0);
            check("flush_no_resp", 64'(resp_valid), 64'd0);
        end else begin
            check("resp_valid", 64'(resp_valid), 64'd1);
            check("resp_idx", 64'(resp_idx), 64'(w));
            check("resp_data", 64'(resp_data), 64'(exp_d));
            check("resp_timeout", 64'(resp_timeout), 64'(exp_t));
            check("resp_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
            check("resp_one_cycle", 64'(resp_valid), 64'd0);
            check("back_idle", 64'(busy), 64'd0);
        end
        rr_m = (w + 1) % N;
    endtask

    initial begin
        int  w;
        bit  fl;
        int  mode;
        int  succ;
        int  fat;
        bit  drop;

        reset_n            = 1'b0;
        req_valid          = '0;
        req_src            = '0;
        req_dst            = '0;
        icon_data_rx       = '0;
        icon_data_valid_rx = 1'b0;
        icon_success       = 1'b0;
        flush              = 1'b0;
        rr_m               = 0;
        req_m              = '0;
        for (int i = 0; i < N; i++) begin
            src_tab[i] = '0;
            dst_tab[i] = '0;
        end

        // Reset state
        #1;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        check_all_zero("post_reset");

        // Round-robin with 1011 held, immediate success: 0,1,3,0
        src_tab[0] = 8'h10; dst_tab[0] = 8'h20;
        src_tab[1] = 8'h11; dst_tab[1] = 8'h21;
        src_tab[3] = 8'h13; dst_tab[3] = 8'h23;
        req_m = 4'b1011;
        apply_req();
        for (int k = 0; k < 4; k++) begin
            do_transfer(1, 0, 1'b0, 1'b0, '0, w, fl);
        end

        // Single request, success on the 3rd BUSY cycle
        req_m = 4'b0001;
        src_tab[0] = 8'h21; dst_tab[0] = 8'h05;
        apply_req();
        do_transfer(3, 0, 1'b0, 1'b1, 32'hDEADBEEF, w, fl);

        // Timeout on requester 2, then a normal transfer
        req_m = 4'b0100;
        apply_req();
        do_transfer(0, 0, 1'b0, 1'b0, '0, w, fl);
        req_m = 4'b1000;
        apply_req();
        do_transfer(2, 0, 1'b0, 1'b0, '0, w, fl);

        // Flush together with success in the 2nd BUSY cycle; next winner
        // must be winner+1
        req_m = 4'b0011;
        apply_req();
        do_transfer(2, 2, 1'b0, 1'b0, '0, w, fl);
        do_transfer(1, 0, 1'b0, 1'b0, '0, w, fl);

        // Flush in IDLE suppresses arbitration for that cycle
        req_m = 4'b0001;
        apply_req();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("idle_flush_busy", 64'(busy), 64'd0);
        check("idle_flush_chan", 64'(icon_req_valid), 64'd0);
        do_transfer(1, 0, 1'b0, 1'b0, '0, w, fl);

        // Reset mid-transfer (model pointer is 1 here)
        req_m = 4'b0010;
        apply_req();
        @(posedge clk); #1;
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        req_m = '0;
        apply_req();
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        check_all_zero("held_reset");
        reset_n = 1'b1;
        rr_m = 0;
        req_m = 4'b0101;
        apply_req();
        do_transfer(1, 0, 1'b0, 1'b0, '0, w, fl);
        req_m = 4'b0100;
        apply_req();
        do_transfer(1, 0, 1'b0, 1'b0, '0, w, fl);
        req_m = '0;
        apply_req();

        // Randomized transfers against the model
        for (int it = 0; it < 30; it++) begin
            if (req_m == '0) add_requests(N'($urandom_range(1, 15)));
            mode = $urandom_range(0, 9);
            succ = (mode == 0) ? 0 : $urandom_range(1, 4);
            fat  = (mode == 1) ? $urandom_range(1, 3) : 0;
            drop = (mode >= 7);
            do_transfer(succ, fat, drop, 1'b0, '0, w, fl);
            if (!fl) begin
                req_m[w] = 1'b0;
                add_requests(N'($urandom_range(0, 15)));
            end else begin
                apply_req();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
